dmem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-cycle processor's shared data memory (`dmemory`). It sits between the CPU load/store port, a debug/loader port and the word-organised memory. The debug/loader port is used by benches and boot logic to preload or inspect memory while the CPU runs. The block grants one word access per cycle, steers the write/read controls to memory, and routes synchronous read data back to the requester that issued it one cycle later. A bounded-wait counter guarantees the debug port cannot be starved.

---
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the shared data memory: CPU has priority, the debug
// port is guaranteed a grant after MAX_WAIT denied cycles; read data is routed back a cycle later.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [31:0]           cpu_wdata,
  input  logic [3:0]            cpu_be,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  input  logic [3:0]            dbg_be,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [31:0]           dbg_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam logic [3:0]            WAIT_LIMIT = 4'(MAX_WAIT);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK  = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  owner_t     rd_owner;
  logic [3:0] wait_cnt;

  // Debug wins contention only once it has been denied MAX_WAIT cycles in a row.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (reset_n) begin
      if (dbg_req && (!cpu_req || wait_cnt == WAIT_LIMIT)) begin
        dbg_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr & WORD_MASK;
      mem_wdata = cpu_wdata;
      mem_be    = cpu_be;
    end else if (dbg_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dbg_we;
      mem_addr  = dbg_addr & WORD_MASK;
      mem_wdata = dbg_wdata;
      mem_be    = dbg_be;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
      rd_owner <= OWN_NONE;
    end else begin
      if (dbg_req && !dbg_gnt) begin
        if (wait_cnt != WAIT_LIMIT) begin
          wait_cnt <= wait_cnt + 4'd1;
        end
      end else begin
        wait_cnt <= 4'd0;
      end

      if (cpu_gnt && !cpu_we) begin
        rd_owner <= OWN_CPU;
      end else if (dbg_gnt && !dbg_we) begin
        rd_owner <= OWN_DBG;
      end else begin
        rd_owner <= OWN_NONE;
      end
    end
  end

  // Gating with reset_n drops the return of a read granted just before reset.
  assign cpu_rvalid = reset_n && (rd_owner == OWN_CPU);
  assign dbg_rvalid = reset_n && (rd_owner == OWN_DBG);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : 32'd0;
  assign dbg_rdata  = dbg_rvalid ? mem_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed test-plan scenarios followed by
// randomized hold-until-grant traffic, checked against a request-level model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int MW = 4;

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_be;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic [3:0]  dbg_be;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_be(cpu_be), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_be(dbg_be), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  // Behavioural dmemory: 16 words aliased on addr[5:2], synchronous read.
  logic [31:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_arr[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
    mem_rdata <= (mem_en && !mem_we) ? mem_arr[mem_addr[5:2]] : 32'hDEAD_BEEF;
  end

  // Reference model state
  logic [31:0] shadow [16];
  int          denied;
  int          prev_owner;
  logic [31:0] prev_data;
  int          n_tests;
  int          n_fail;
  req_t        idle;
  req_t        cp, dp;
  int          w;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic req_t mk(input logic req, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
    req_t r;
    r.req = req; r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input logic rst, input req_t c, input req_t d, output int win);
    req_t g;
    int   eo;
    @(negedge clk);
    reset_n   = rst;
    cpu_req   = c.req; cpu_we = c.we; cpu_addr = c.addr; cpu_wdata = c.wdata; cpu_be = c.be;
    dbg_req   = d.req; dbg_we = d.we; dbg_addr = d.addr; dbg_wdata = d.wdata; dbg_be = d.be;
    #1;
    if (!rst)                win = 0;
    else if (c.req && d.req) win = (denied >= MW) ? 2 : 1;
    else if (c.req)          win = 1;
    else if (d.req)          win = 2;
    else                     win = 0;
    g = (win == 1) ? c : (win == 2) ? d : idle;

    check("cpu_gnt",   32'(cpu_gnt),   32'(win == 1));
    check("dbg_gnt",   32'(dbg_gnt),   32'(win == 2));
    check("mem_en",    32'(mem_en),    32'(win != 0));
    check("mem_we",    32'(mem_we),    32'(g.we));
    check("mem_addr",  mem_addr,       {g.addr[31:2], 2'b00});
    check("mem_wdata", mem_wdata,      g.wdata);
    check("mem_be",    32'(mem_be),    32'(g.be));

    eo = rst ? prev_owner : 0;
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(eo == 1));
    check("cpu_rdata",  cpu_rdata,       (eo == 1) ? prev_data : 32'd0);
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(eo == 2));
    check("dbg_rdata",  dbg_rdata,       (eo == 2) ? prev_data : 32'd0);

    prev_owner = 0;
    if (win != 0) begin
      if (g.we) shadow[g.addr[5:2]] = merge(shadow[g.addr[5:2]], g.wdata, g.be);
      else begin
        prev_owner = win;
        prev_data  = shadow[g.addr[5:2]];
      end
    end
    if (!rst || !d.req || win == 2) denied = 0;
    else if (denied < MW)           denied++;
  endtask

  initial begin
    n_tests = 0; n_fail = 0; denied = 0; prev_owner = 0; prev_data = '0;
    idle = mk(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = '0;
      shadow[i]  = '0;
    end

    // Reset state, including requests held during reset
    step(1'b0, idle, idle, w);
    step(1'b0, mk(1, 0, 32'h10, 0, 4'hF), mk(1, 1, 32'h20, 32'h55, 4'hF), w);
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("rst_mem_en",  32'(mem_en),  32'd0);

    // Debug preload
    for (int i = 0; i < 4; i++) step(1'b1, idle, mk(1, 1, 32'(4*i), 32'hFEFE_FEFE, 4'hF), w);
    step(1'b1, idle, idle, w);
    for (int i = 0; i < 4; i++) check($sformatf("preload_w%0d", i), mem_arr[i], 32'hFEFE_FEFE);

    // CPU read of unaligned address 0x6
    step(1'b1, mk(1, 0, 32'h6, 0, 4'hF), idle, w);
    check("rd6_mem_addr", mem_addr, 32'h4);
    step(1'b1, idle, idle, w);
    check("rd6_rvalid", 32'(cpu_rvalid), 32'd1);
    check("rd6_rdata",  cpu_rdata,       32'hFEFE_FEFE);
    check("rd6_dbg_rv", 32'(dbg_rvalid), 32'd0);

    // Contention and starvation
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(1, 0, 32'h0, 0, 4'hF), mk(1, 0, 32'h8, 0, 4'hF), w);
      check($sformatf("starve_dbg_gnt%0d", i), 32'(dbg_gnt), 32'(i % 5 == 4));
    end
    step(1'b1, idle, idle, w);

    // Interleaved reads
    step(1'b1, mk(1, 0, 32'h0, 0, 4'hF), idle, w);
    step(1'b1, idle, mk(1, 0, 32'h4, 0, 4'hF), w);
    check("il_cpu_rv", 32'(cpu_rvalid), 32'd1);
    check("il_cpu_rd", cpu_rdata,       32'hFEFE_FEFE);
    check("il_dbg_rv", 32'(dbg_rvalid), 32'd0);
    step(1'b1, idle, idle, w);
    check("il_dbg_rv2", 32'(dbg_rvalid), 32'd1);
    check("il_dbg_rd2", dbg_rdata,       32'hFEFE_FEFE);
    check("il_cpu_rv2", 32'(cpu_rvalid), 32'd0);

    // Partial write, and a write/read with no byte enables
    step(1'b1, mk(1, 1, 32'h0, 32'h1234_5678, 4'b0101), idle, w);
    step(1'b1, mk(1, 1, 32'h4, 32'h0000_0000, 4'b0000), idle, w);
    step(1'b1, mk(1, 0, 32'h0, 0, 4'hF), idle, w);
    step(1'b1, mk(1, 0, 32'h4, 0, 4'h0), idle, w);
    check("pw_rdata", cpu_rdata, 32'hFE34_FE78);
    step(1'b1, idle, idle, w);
    check("be0_rdata", cpu_rdata, 32'hFEFE_FEFE);

    // Reset mid-read
    step(1'b1, mk(1, 0, 32'h8, 0, 4'hF), mk(1, 0, 32'hC, 0, 4'hF), w);
    step(1'b0, mk(1, 0, 32'h8, 0, 4'hF), mk(1, 0, 32'hC, 0, 4'hF), w);
    check("mr_cpu_rv",  32'(cpu_rvalid), 32'd0);
    check("mr_dbg_gnt", 32'(dbg_gnt),    32'd0);
    step(1'b0, mk(1, 0, 32'h8, 0, 4'hF), mk(1, 0, 32'hC, 0, 4'hF), w);
    step(1'b1, mk(1, 0, 32'h8, 0, 4'hF), mk(1, 0, 32'hC, 0, 4'hF), w);
    check("mr_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    step(1'b1, idle, idle, w);

    // Randomized traffic: requesters hold request and payload until granted
    cp = idle; dp = idle;
    for (int n = 0; n < 400; n++) begin
      if (!cp.req && $urandom_range(0, 2) != 0)
        cp = mk(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      if (!dp.req && $urandom_range(0, 2) != 0)
        dp = mk(1'b1, 1'($urandom_range(0, 1)), $urandom(), $urandom(), 4'($urandom_range(0, 15)));
      step(($urandom_range(0, 49) != 0), cp, dp, w);
      if (w == 1) cp = idle;
      if (w == 2) dp = idle;
    end
    step(1'b1, idle, idle, w);
    for (int i = 0; i < 16; i++) check($sformatf("final_w%0d", i), mem_arr[i], shadow[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
